// File: rtl/store_buffer_pkg.sv
// Shared store-buffer definitions: DM mode codes, entry layout, byte-mask and load-extend helpers.
// Used by store_buffer and sb_byte_mask; the SB_FWD_EN build also uses sb_load_extend.
package store_buffer_pkg;

    localparam logic [3:0] DM_WORD          = 4'd1;
    localparam logic [3:0] DM_HALF          = 4'd2;
    localparam logic [3:0] DM_HALF_UNSIGNED = 4'd3;
    localparam logic [3:0] DM_BYTE          = 4'd4;
    localparam logic [3:0] DM_BYTE_UNSIGNED = 4'd5;

    typedef struct packed {
        logic [3:0]  mode;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
        logic [3:0]  mask;
    } sb_entry_t;

    // Unsigned load modes touch the same lanes as their signed counterparts.
    function automatic logic [3:0] sb_mask(input logic [3:0] mode, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (mode)
            DM_WORD:                   mask = 4'b1111;
            DM_HALF, DM_HALF_UNSIGNED: mask = 4'b0011 << {addr_lo[1], 1'b0};
            DM_BYTE, DM_BYTE_UNSIGNED: mask = 4'b0001 << addr_lo;
            default:                   mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Selects and extends a byte/half out of a stored word, as DM would return it.
    function automatic logic [31:0] sb_load_extend(input logic [31:0] word,
                                                   input logic [3:0]  mode,
                                                   input logic [1:0]  addr_lo);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (mode)
            DM_HALF:          r = {{16{h[15]}}, h};
            DM_HALF_UNSIGNED: r = {16'h0000, h};
            DM_BYTE:          r = {{24{b[7]}}, b};
            DM_BYTE_UNSIGNED: r = {24'h000000, b};
            default:          r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sb_byte_mask.sv
// Byte-lane mask for a DM access: mode and address low bits in, 4-bit lane mask out.
module sb_byte_mask
    import store_buffer_pkg::*;
(
    input  logic [3:0] i_mode,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_mask
);

    assign o_mask = sb_mask(i_mode, i_addr_lo);

endmodule

// File: rtl/store_buffer.sv
// In-order store FIFO between MEM and DM; drains one store per cycle when loads leave the port free.
// Optional SB_FWD_EN: loads whose youngest overlapping entry is a word store are forwarded.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SB_i_Valid,
    input  logic [3:0]  SB_i_Mode,
    input  logic [31:0] SB_i_Addr,
    input  logic [31:0] SB_i_WData,
    input  logic [31:0] SB_i_PC,
    output logic        SB_o_Ready,
    input  logic        SB_i_LoadActive,
    input  logic [3:0]  SB_i_LdMode,
    input  logic [31:0] SB_i_LdAddr,
    output logic        SB_o_LdStall,
    output logic        SB_o_LdFwdValid,
    output logic [31:0] SB_o_LdFwdData,
    output logic        SB_o_DMWEnable,
    output logic [3:0]  SB_o_DMMode,
    output logic [31:0] SB_o_DMAddr,
    output logic [31:0] SB_o_DMWData,
    output logic [31:0] SB_o_DMPC,
    output logic        SB_o_Empty
);

    localparam int unsigned      PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

    sb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_enq;
    logic             w_pop;
    logic             w_empty;
    logic [3:0]       w_st_mask;
    logic [3:0]       w_ld_mask;
    logic [PTR_W-1:0] w_off [DEPTH];
    logic [DEPTH-1:0] w_ovl;
    logic             w_any_ovl;
    logic             w_fwd_valid;
    logic [31:0]      w_fwd_data;
    sb_entry_t        w_head;

    sb_byte_mask u_st_mask (
        .i_mode    (SB_i_Mode),
        .i_addr_lo (SB_i_Addr[1:0]),
        .o_mask    (w_st_mask)
    );

    sb_byte_mask u_ld_mask (
        .i_mode    (SB_i_LdMode),
        .i_addr_lo (SB_i_LdAddr[1:0]),
        .o_mask    (w_ld_mask)
    );

    assign w_empty    = (r_count == '0);
    assign SB_o_Empty = w_empty;
    assign SB_o_Ready = (r_count != FULL_COUNT);
    assign w_enq      = SB_i_Valid && SB_o_Ready;

    // Offset from head decides validity; the pointers alone cannot tell full from empty.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_off[i] = PTR_W'(i) - r_head;
            w_ovl[i] = ({1'b0, w_off[i]} < r_count) &&
                       (r_mem[i].addr[31:2] == SB_i_LdAddr[31:2]) &&
                       ((r_mem[i].mask & w_ld_mask) != 4'b0000);
        end
    end

    assign w_any_ovl = |w_ovl;

`ifdef SB_FWD_EN
    logic [PTR_W-1:0] w_young_idx;
    logic [PTR_W-1:0] w_young_off;

    always_comb begin
        w_young_idx = '0;
        w_young_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ovl[i] && (w_off[i] >= w_young_off)) begin
                w_young_idx = PTR_W'(i);
                w_young_off = w_off[i];
            end
        end
    end

    assign w_fwd_valid = SB_i_LoadActive && w_any_ovl && (r_mem[w_young_idx].mode == DM_WORD);
    assign w_fwd_data  = w_fwd_valid ?
                         sb_load_extend(r_mem[w_young_idx].data, SB_i_LdMode, SB_i_LdAddr[1:0]) :
                         32'h0000_0000;
`else
    assign w_fwd_valid = 1'b0;
    assign w_fwd_data  = 32'h0000_0000;
`endif

    assign SB_o_LdFwdValid = w_fwd_valid;
    assign SB_o_LdFwdData  = w_fwd_data;
    assign SB_o_LdStall    = SB_i_LoadActive && w_any_ovl && !w_fwd_valid;

    // A stalled load leaves the port idle, so the blocking store can always drain.
    assign w_pop          = !w_empty && (!SB_i_LoadActive || SB_o_LdStall);
    assign SB_o_DMWEnable = w_pop;

    assign w_head       = r_mem[r_head];
    assign SB_o_DMMode  = w_empty ? 4'h0          : w_head.mode;
    assign SB_o_DMAddr  = w_empty ? 32'h0000_0000 : w_head.addr;
    assign SB_o_DMWData = w_empty ? 32'h0000_0000 : w_head.data;
    assign SB_o_DMPC    = w_empty ? 32'h0000_0000 : w_head.pc;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail] <= '{mode: SB_i_Mode, addr: SB_i_Addr, data: SB_i_WData,
                               pc: SB_i_PC, mask: w_st_mask};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer; expectations switch on SB_FWD_EN.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        SB_i_Valid;
    logic [3:0]  SB_i_Mode;
    logic [31:0] SB_i_Addr;
    logic [31:0] SB_i_WData;
    logic [31:0] SB_i_PC;
    logic        SB_o_Ready;
    logic        SB_i_LoadActive;
    logic [3:0]  SB_i_LdMode;
    logic [31:0] SB_i_LdAddr;
    logic        SB_o_LdStall;
    logic        SB_o_LdFwdValid;
    logic [31:0] SB_o_LdFwdData;
    logic        SB_o_DMWEnable;
    logic [3:0]  SB_o_DMMode;
    logic [31:0] SB_o_DMAddr;
    logic [31:0] SB_o_DMWData;
    logic [31:0] SB_o_DMPC;
    logic        SB_o_Empty;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] drain_addr [$];
    logic [31:0] drain_data [$];
    logic [31:0] dm_mem [logic [29:0]];
    bit          allow_both = 1'b0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .SB_i_Valid      (SB_i_Valid),
        .SB_i_Mode       (SB_i_Mode),
        .SB_i_Addr       (SB_i_Addr),
        .SB_i_WData      (SB_i_WData),
        .SB_i_PC         (SB_i_PC),
        .SB_o_Ready      (SB_o_Ready),
        .SB_i_LoadActive (SB_i_LoadActive),
        .SB_i_LdMode     (SB_i_LdMode),
        .SB_i_LdAddr     (SB_i_LdAddr),
        .SB_o_LdStall    (SB_o_LdStall),
        .SB_o_LdFwdValid (SB_o_LdFwdValid),
        .SB_o_LdFwdData  (SB_o_LdFwdData),
        .SB_o_DMWEnable  (SB_o_DMWEnable),
        .SB_o_DMMode     (SB_o_DMMode),
        .SB_o_DMAddr     (SB_o_DMAddr),
        .SB_o_DMWData    (SB_o_DMWData),
        .SB_o_DMPC       (SB_o_DMPC),
        .SB_o_Empty      (SB_o_Empty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic dm_write(input logic [3:0] mode, input logic [31:0] addr,
                            input logic [31:0] data);
        logic [31:0] word;
        word = dm_mem.exists(addr[31:2]) ? dm_mem[addr[31:2]] : 32'h0;
        case (mode)
            DM_WORD: word = data;
            DM_HALF: if (addr[1]) word[31:16] = data[15:0]; else word[15:0] = data[15:0];
            DM_BYTE: word[{addr[1:0], 3'b000} +: 8] = data[7:0];
            default: check("dm_mode", {28'h0, mode}, {28'h0, DM_WORD});
        endcase
        dm_mem[addr[31:2]] = word;
    endtask

    // DM side: takes drains on the clock edge, and polices the single-MEM-op rule.
    always @(posedge clk) begin
        if (!reset && SB_o_DMWEnable) begin
            drain_addr.push_back(SB_o_DMAddr);
            drain_data.push_back(SB_o_DMWData);
            dm_write(SB_o_DMMode, SB_o_DMAddr, SB_o_DMWData);
        end
        if (!reset && !allow_both && SB_i_Valid && SB_i_LoadActive) begin
            check("one_mem_op", 32'd1, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_store(input bit v, input logic [3:0] mode, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] pc);
        SB_i_Valid = v;
        SB_i_Mode  = mode;
        SB_i_Addr  = addr;
        SB_i_WData = data;
        SB_i_PC    = pc;
    endtask

    task automatic set_load(input bit a, input logic [3:0] mode, input logic [31:0] addr);
        SB_i_LoadActive = a;
        SB_i_LdMode     = mode;
        SB_i_LdAddr     = addr;
    endtask

    initial begin
        reset = 1'b1;
        set_store(1'b0, DM_WORD, 32'h0, 32'h0, 32'h0);
        set_load(1'b0, DM_WORD, 32'h0);
        #12;
        check("rst_ready", SB_o_Ready, 1);
        check("rst_empty", SB_o_Empty, 1);
        check("rst_we", SB_o_DMWEnable, 0);
        check("rst_stall", SB_o_LdStall, 0);
        check("rst_fwdv", SB_o_LdFwdValid, 0);
        check("rst_fwdd", SB_o_LdFwdData, 32'h0);
        check("rst_dmaddr", SB_o_DMAddr, 32'h0);
        check("rst_dmdata", SB_o_DMWData, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Single word store drains the cycle after enqueue.
        set_store(1'b1, DM_WORD, 32'h10, 32'h1234_5678, 32'h3000);
        tick();
        set_store(1'b0, DM_WORD, 32'h0, 32'h0, 32'h0);
        #1;
        check("t1_we", SB_o_DMWEnable, 1);
        check("t1_addr", SB_o_DMAddr, 32'h10);
        check("t1_data", SB_o_DMWData, 32'h1234_5678);
        check("t1_pc", SB_o_DMPC, 32'h3000);
        check("t1_mode", {28'h0, SB_o_DMMode}, {28'h0, DM_WORD});
        check("t1_empty", SB_o_Empty, 0);
        tick();
        check("t1_empty_after", SB_o_Empty, 1);
        check("t1_we_after", SB_o_DMWEnable, 0);
        check("t1_ndrain", drain_addr.size(), 1);

        // Fill with the port held by a non-overlapping load.
        allow_both = 1'b1;
        set_load(1'b1, DM_WORD, 32'h1000);
        for (int i = 0; i < 4; i++) begin
            set_store(1'b1, DM_WORD, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 32'h4000);
            tick();
            check("t2_no_drain", SB_o_DMWEnable, 0);
        end
        check("t2_ready_full", SB_o_Ready, 0);
        check("t2_stall", SB_o_LdStall, 0);
        set_store(1'b1, DM_WORD, 32'h110, 32'hA4, 32'h4000);
        tick();
        check("t2_ready_held", SB_o_Ready, 0);
        check("t2_ndrain_held", drain_addr.size(), 1);
        set_store(1'b0, DM_WORD, 32'h0, 32'h0, 32'h0);
        set_load(1'b0, DM_WORD, 32'h0);
        allow_both = 1'b0;
        #1;
        check("t2_we", SB_o_DMWEnable, 1);
        check("t2_head", SB_o_DMAddr, 32'h100);
        tick();
        check("t2_ready_back", SB_o_Ready, 1);
        set_store(1'b1, DM_WORD, 32'h110, 32'hA4, 32'h4000);
        tick();
        set_store(1'b0, DM_WORD, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (SB_o_Empty) break;
            tick();
        end
        check("t2_drained", SB_o_Empty, 1);
        check("t2_ndrain", drain_addr.size(), 6);
        for (int i = 0; i < 5; i++) begin
            if (drain_addr.size() > i + 1) begin
                check("t2_order_addr", drain_addr[i + 1], 32'h100 + 32'(4 * i));
                check("t2_order_data", drain_data[i + 1], 32'hA0 + 32'(i));
            end
        end

        // Byte store blocks an overlapping lbu until it drains.
        set_store(1'b1, DM_BYTE, 32'h21, 32'hAB, 32'h5000);
        tick();
        set_store(1'b0, DM_WORD, 32'h0, 32'h0, 32'h0);
        set_load(1'b1, DM_BYTE_UNSIGNED, 32'h21);
        #1;
        check("t3_stall", SB_o_LdStall, 1);
        check("t3_we", SB_o_DMWEnable, 1);
        check("t3_fwdv", SB_o_LdFwdValid, 0);
        tick();
        check("t3_stall_clear", SB_o_LdStall, 0);
        check("t3_we_after", SB_o_DMWEnable, 0);
        check("t3_dm_read", (dm_mem[30'h8] >> 8) & 32'hFF, 32'h0000_00AB);
        set_load(1'b0, DM_WORD, 32'h0);

        // Half store at 0x42: lanes 2/3 of word 0x40.
        set_store(1'b1, DM_HALF, 32'h42, 32'hBEEF, 32'h6000);
        tick();
        set_store(1'b0, DM_WORD, 32'h0, 32'h0, 32'h0);
        set_load(1'b1, DM_WORD, 32'h44);
        #1;
        check("t4_lw_stall", SB_o_LdStall, 0);
        check("t4_lw_we", SB_o_DMWEnable, 0);
        tick();
        check("t4_blocked", SB_o_Empty, 0);
        set_load(1'b1, DM_BYTE_UNSIGNED, 32'h41);
        #1;
        check("t4_lane_miss", SB_o_LdStall, 0);
        set_load(1'b1, DM_BYTE_UNSIGNED, 32'h43);
        #1;
        check("t4_lane_hit", SB_o_LdStall, 1);
        check("t4_we", SB_o_DMWEnable, 1);
        tick();
        check("t4_empty", SB_o_Empty, 1);
        check("t4_dm_half", dm_mem[30'h10] >> 16, 32'h0000_BEEF);
        set_load(1'b0, DM_WORD, 32'h0);

        // Word store: forwarded or stalled depending on build.
        set_store(1'b1, DM_WORD, 32'h50, 32'h8000_FF7F, 32'h7000);
        tick();
        set_store(1'b0, DM_WORD, 32'h0, 32'h0, 32'h0);
        set_load(1'b1, DM_BYTE, 32'h51);
        #1;
`ifdef SB_FWD_EN
        check("t5_lb_fwdv", SB_o_LdFwdValid, 1);
        check("t5_lb_data", SB_o_LdFwdData, 32'hFFFF_FFFF);
        check("t5_lb_stall", SB_o_LdStall, 0);
        check("t5_lb_we", SB_o_DMWEnable, 0);
`else
        check("t5_lb_fwdv", SB_o_LdFwdValid, 0);
        check("t5_lb_data", SB_o_LdFwdData, 32'h0);
        check("t5_lb_stall", SB_o_LdStall, 1);
        check("t5_lb_we", SB_o_DMWEnable, 1);
`endif
        set_load(1'b1, DM_HALF_UNSIGNED, 32'h52);
        #1;
`ifdef SB_FWD_EN
        check("t5_lhu_data", SB_o_LdFwdData, 32'h0000_8000);
        check("t5_lhu_stall", SB_o_LdStall, 0);
`else
        check("t5_lhu_data", SB_o_LdFwdData, 32'h0);
        check("t5_lhu_stall", SB_o_LdStall, 1);
`endif
        set_load(1'b0, DM_WORD, 32'h0);
        tick();
        check("t5_empty", SB_o_Empty, 1);

        // Younger byte store over an older word: never forwardable.
        set_store(1'b1, DM_WORD, 32'h60, 32'h1111_1111, 32'h7100);
        tick();
        set_store(1'b1, DM_BYTE, 32'h60, 32'h22, 32'h7104);
        tick();
        set_store(1'b0, DM_WORD, 32'h0, 32'h0, 32'h0);
        set_load(1'b1, DM_BYTE_UNSIGNED, 32'h60);
        #1;
        check("t5_young_stall", SB_o_LdStall, 1);
        check("t5_young_fwdv", SB_o_LdFwdValid, 0);
        set_load(1'b0, DM_WORD, 32'h0);
        tick();
        tick();
        check("t5_young_empty", SB_o_Empty, 1);
        check("t5_dm_word", dm_mem[30'h18], 32'h1111_1122);

        // Asynchronous reset mid-cycle with three held entries.
        allow_both = 1'b1;
        set_load(1'b1, DM_WORD, 32'h2000);
        for (int i = 0; i < 3; i++) begin
            set_store(1'b1, DM_WORD, 32'h70 + 32'(4 * i), 32'hC0 + 32'(i), 32'h8000);
            tick();
        end
        set_store(1'b0, DM_WORD, 32'h0, 32'h0, 32'h0);
        check("t6_held", SB_o_Empty, 0);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_empty", SB_o_Empty, 1);
        check("t6_rst_we", SB_o_DMWEnable, 0);
        check("t6_rst_ready", SB_o_Ready, 1);
        check("t6_rst_addr", SB_o_DMAddr, 32'h0);
        set_load(1'b0, DM_WORD, 32'h0);
        allow_both = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) tick();
        check("t6_no_drain", drain_addr.size(), 11);
        check("t6_empty", SB_o_Empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
